// File: rtl/c7b_biu_rd_arb_if.sv
// Bundle of ICU/DCU requester ports and the shared BIU read port around c7b_biu_rd_arb.
// slave = arbiter view, master = the surrounding requesters and BIU.
interface c7b_biu_rd_arb_if #(
  parameter int DATA_W = 64
);
  logic              icu_arb_req;
  logic [28:0]       icu_arb_addr;
  logic              icu_arb_single;
  logic              arb_icu_ack;
  logic              arb_icu_data_valid;
  logic              arb_icu_data_last;
  logic [DATA_W-1:0] arb_icu_data;
  logic              arb_icu_fault;

  logic              dcu_arb_req;
  logic [28:0]       dcu_arb_addr;
  logic              dcu_arb_single;
  logic              arb_dcu_ack;
  logic              arb_dcu_data_valid;
  logic              arb_dcu_data_last;
  logic [DATA_W-1:0] arb_dcu_data;
  logic              arb_dcu_fault;

  logic              arb_biu_req;
  logic [28:0]       arb_biu_addr;
  logic              arb_biu_single;
  logic              biu_arb_ack;
  logic              biu_arb_data_valid;
  logic              biu_arb_data_last;
  logic [DATA_W-1:0] biu_arb_data;
  logic              biu_arb_fault;

  logic              arb_busy;
  logic              arb_proto_err;

  modport slave (
    input  icu_arb_req, icu_arb_addr, icu_arb_single,
    output arb_icu_ack, arb_icu_data_valid, arb_icu_data_last, arb_icu_data, arb_icu_fault,
    input  dcu_arb_req, dcu_arb_addr, dcu_arb_single,
    output arb_dcu_ack, arb_dcu_data_valid, arb_dcu_data_last, arb_dcu_data, arb_dcu_fault,
    output arb_biu_req, arb_biu_addr, arb_biu_single,
    input  biu_arb_ack, biu_arb_data_valid, biu_arb_data_last, biu_arb_data, biu_arb_fault,
    output arb_busy, arb_proto_err
  );

  modport master (
    output icu_arb_req, icu_arb_addr, icu_arb_single,
    input  arb_icu_ack, arb_icu_data_valid, arb_icu_data_last, arb_icu_data, arb_icu_fault,
    output dcu_arb_req, dcu_arb_addr, dcu_arb_single,
    input  arb_dcu_ack, arb_dcu_data_valid, arb_dcu_data_last, arb_dcu_data, arb_dcu_fault,
    input  arb_biu_req, arb_biu_addr, arb_biu_single,
    output biu_arb_ack, biu_arb_data_valid, biu_arb_data_last, biu_arb_data, biu_arb_fault,
    input  arb_busy, arb_proto_err
  );
endinterface

// File: rtl/c7b_biu_rd_arb.sv
// Round-robin ICU/DCU read arbiter onto the single BIU read port; one transaction in flight,
// grant held until the last beat, beat-count and stray-response checking.
module c7b_biu_rd_arb #(
  parameter int BURST_LEN = 4,
  parameter int DATA_W    = 64
) (
  input  logic                clk,
  input  logic                reset,
  c7b_biu_rd_arb_if.slave     io_bus
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA} state_t;
  typedef enum logic {OWN_ICU = 1'b0, OWN_DCU = 1'b1} owner_t;

  localparam int CNT_W = ($clog2(BURST_LEN) + 1 < 2) ? 2 : $clog2(BURST_LEN) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            r_state;
  owner_t            r_owner;
  owner_t            r_last_served;
  logic [28:0]       r_addr;
  logic              r_single;
  logic [CNT_W-1:0]  r_beat_cnt;
  logic              r_biu_req;
  logic              r_busy;
  logic              r_proto_err;

  logic              w_ack_ok;
  logic              w_beat_ok;
  logic              w_grant_dcu;
  logic              w_stray;
  logic [CNT_W-1:0]  w_exp_m1;
  logic              w_icu_vld;
  logic              w_dcu_vld;

  // Responses only count while reset is low and the FSM is in the matching phase.
  assign w_ack_ok    = !reset && (r_state == S_REQ)  && io_bus.biu_arb_ack;
  assign w_beat_ok   = !reset && (r_state == S_DATA) && io_bus.biu_arb_data_valid;
  assign w_grant_dcu = io_bus.dcu_arb_req &&
                       (!io_bus.icu_arb_req || (r_last_served == OWN_ICU));
  assign w_stray     = (io_bus.biu_arb_ack && (r_state != S_REQ)) ||
                       (io_bus.biu_arb_data_valid && (r_state != S_DATA));
  // beat_cnt holds beats already seen, so the last beat must arrive with cnt == expected-1.
  assign w_exp_m1    = r_single ? '0 : CNT_W'(BURST_LEN - 1);

  assign w_icu_vld = w_beat_ok && (r_owner == OWN_ICU);
  assign w_dcu_vld = w_beat_ok && (r_owner == OWN_DCU);

  assign io_bus.arb_icu_ack        = w_ack_ok && (r_owner == OWN_ICU);
  assign io_bus.arb_icu_data_valid = w_icu_vld;
  assign io_bus.arb_icu_data_last  = w_icu_vld && io_bus.biu_arb_data_last;
  assign io_bus.arb_icu_fault      = w_icu_vld && io_bus.biu_arb_fault;
  assign io_bus.arb_icu_data       = w_icu_vld ? io_bus.biu_arb_data : {DATA_W{1'b0}};

  assign io_bus.arb_dcu_ack        = w_ack_ok && (r_owner == OWN_DCU);
  assign io_bus.arb_dcu_data_valid = w_dcu_vld;
  assign io_bus.arb_dcu_data_last  = w_dcu_vld && io_bus.biu_arb_data_last;
  assign io_bus.arb_dcu_fault      = w_dcu_vld && io_bus.biu_arb_fault;
  assign io_bus.arb_dcu_data       = w_dcu_vld ? io_bus.biu_arb_data : {DATA_W{1'b0}};

  assign io_bus.arb_biu_req    = r_biu_req;
  assign io_bus.arb_biu_addr   = r_addr;
  assign io_bus.arb_biu_single = r_single;
  assign io_bus.arb_busy       = r_busy;
  assign io_bus.arb_proto_err  = r_proto_err;

  // NOTE: every register here uses <= so all updates see the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_owner       <= OWN_ICU;
      r_last_served <= OWN_DCU;
      r_addr        <= '0;
      r_single      <= 1'b0;
      r_beat_cnt    <= '0;
      r_biu_req     <= 1'b0;
      r_busy        <= 1'b0;
      r_proto_err   <= 1'b0;
    end else begin
      if (w_stray) r_proto_err <= 1'b1;
      unique case (r_state)
        S_IDLE: begin
          if (io_bus.icu_arb_req || io_bus.dcu_arb_req) begin
            r_owner   <= w_grant_dcu ? OWN_DCU : OWN_ICU;
            r_addr    <= w_grant_dcu ? io_bus.dcu_arb_addr   : io_bus.icu_arb_addr;
            r_single  <= w_grant_dcu ? io_bus.dcu_arb_single : io_bus.icu_arb_single;
            r_state   <= S_REQ;
            r_biu_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_REQ: begin
          if (io_bus.biu_arb_ack) begin
            r_beat_cnt <= '0;
            r_state    <= S_DATA;
            r_biu_req  <= 1'b0;
          end
        end
        S_DATA: begin
          if (io_bus.biu_arb_data_valid) begin
            if (r_beat_cnt != CNT_MAX) r_beat_cnt <= r_beat_cnt + CNT_W'(1);
            if (io_bus.biu_arb_data_last) begin
              if (r_beat_cnt != w_exp_m1) r_proto_err <= 1'b1;
              r_last_served <= r_owner;
              r_state       <= S_IDLE;
              r_busy        <= 1'b0;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
